// File: rtl/pcieifc_fifo_pkg.sv
// Shared helpers for the PCIe interface FIFOs: storage capacity and occupancy-count width.
package pcieifc_fifo_pkg;

  // Words the FIFO can hold: the RAM plus the output stage when in fall-through mode.
  function automatic int unsigned cap(input int unsigned asize, input bit fwft);
    return (32'd1 << asize) + (fwft ? 32'd1 : 32'd0);
  endfunction

  function automatic int unsigned cnt_w(input int unsigned asize);
    return asize + 2;
  endfunction

endpackage

// File: rtl/pcieifc_sdp_ram.sv
// Simple dual-port RAM: synchronous write, registered read whose output register
// clears on rst; the array itself is never reset.
module pcieifc_sdp_ram #(
  parameter int unsigned DSIZE = 8,
  parameter int unsigned ASIZE = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [ASIZE-1:0] waddr,
  input  logic [DSIZE-1:0] wdata,
  input  logic             re,
  input  logic [ASIZE-1:0] raddr,
  output logic [DSIZE-1:0] rdata
);

  localparam int unsigned DEPTH = 1 << ASIZE;

  logic [DSIZE-1:0] mem [DEPTH];
  logic [DSIZE-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_q <= '0;
    end else if (re) begin
      rdata_q <= mem[raddr];
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/pcieifc_sync_fifo_fwft.sv
// Single-clock FIFO with optional first-word-fall-through output stage, occupancy count,
// almost-full/almost-empty thresholds and sticky overflow/underflow flags.
module pcieifc_sync_fifo_fwft
  import pcieifc_fifo_pkg::*;
#(
  parameter int unsigned DSIZE         = 8,
  parameter int unsigned ASIZE         = 4,
  parameter bit          FWFT          = 1'b1,
  parameter int unsigned AFULL_THRESH  = (1 << ASIZE) - 2,
  parameter int unsigned AEMPTY_THRESH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             wen,
  input  logic [DSIZE-1:0] din,
  output logic             full,
  output logic             almost_full,
  input  logic             ren,
  output logic [DSIZE-1:0] dout,
  output logic             empty,
  output logic             almost_empty,
  output logic [ASIZE+1:0] count,
  output logic             overflow,
  output logic             underflow
);

  localparam int unsigned CntW = cnt_w(ASIZE);
  localparam logic [ASIZE:0] PtrOne = {{ASIZE{1'b0}}, 1'b1};

  if (ASIZE < 1) begin : g_bad_asize
    $error("pcieifc_sync_fifo_fwft: ASIZE must be at least 1");
  end
  if (AFULL_THRESH > cap(ASIZE, FWFT)) begin : g_bad_afull
    $error("pcieifc_sync_fifo_fwft: AFULL_THRESH exceeds FIFO capacity");
  end

  logic [ASIZE:0]    waddr_q, raddr_q, ram_used;
  logic              vld_q, vld_d, ovf_q, udf_q;
  logic              flush, ram_empty, ram_full, wr_acc, rd_issue;
  logic [CntW-1:0]   count_w;

  assign flush     = rst | clr;
  assign ram_used  = waddr_q - raddr_q;
  assign ram_empty = (waddr_q == raddr_q);
  assign ram_full  = (waddr_q[ASIZE-1:0] == raddr_q[ASIZE-1:0]) &&
                     (waddr_q[ASIZE] != raddr_q[ASIZE]);
  assign full      = ram_full;
  assign wr_acc    = wen & ~full;

  // ram_empty is judged before this cycle's write, so a read never hits the write address.
  always_comb begin
    vld_d = 1'b0;
    if (FWFT) begin
      empty    = ~vld_q;
      rd_issue = ~ram_empty & (~vld_q | ren);
      if (rd_issue) begin
        vld_d = 1'b1;
      end else if (ren && vld_q) begin
        vld_d = 1'b0;
      end else begin
        vld_d = vld_q;
      end
    end else begin
      empty    = ram_empty;
      rd_issue = ren & ~ram_empty;
    end
  end

  always_ff @(posedge clk) begin
    if (flush) begin
      waddr_q <= '0;
      raddr_q <= '0;
      vld_q   <= 1'b0;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
    end else begin
      if (wr_acc) begin
        waddr_q <= waddr_q + PtrOne;
      end
      if (rd_issue) begin
        raddr_q <= raddr_q + PtrOne;
      end
      vld_q <= vld_d;
      if (wen && full) begin
        ovf_q <= 1'b1;
      end
      if (ren && empty) begin
        udf_q <= 1'b1;
      end
    end
  end

  pcieifc_sdp_ram #(
    .DSIZE (DSIZE),
    .ASIZE (ASIZE)
  ) u_ram (
    .clk   (clk),
    .rst   (flush),
    .we    (wr_acc & ~flush),
    .waddr (waddr_q[ASIZE-1:0]),
    .wdata (din),
    .re    (rd_issue & ~flush),
    .raddr (raddr_q[ASIZE-1:0]),
    .rdata (dout)
  );

  assign count_w      = CntW'(ram_used) + CntW'(vld_q);
  assign count        = count_w;
  assign almost_full  = 32'(count_w) >= AFULL_THRESH;
  assign almost_empty = 32'(count_w) <= AEMPTY_THRESH;
  assign overflow     = ovf_q;
  assign underflow    = udf_q;

endmodule

// File: tb/tb_pcieifc_sync_fifo_fwft.sv
// Bench for pcieifc_sync_fifo_fwft: a standard-mode and a fall-through instance share
// stimulus and are each compared every cycle against a queue model.
module tb_pcieifc_sync_fifo_fwft;

  localparam int Depth = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, clr, wen, ren;
  logic [7:0] din;
  logic [1:0] full_w, afull_w, empty_w, aempty_w, ovf_w, udf_w;
  logic [1:0][7:0] dout_w;
  logic [1:0][3:0] count_w;

  int checks = 0;
  int failures = 0;
  bit chk_en = 1'b0;

  // Instance 0: standard read mode; instance 1: fall-through.
  for (genvar g = 0; g < 2; g++) begin : g_dut
    pcieifc_sync_fifo_fwft #(
      .DSIZE (8),
      .ASIZE (2),
      .FWFT  (g == 1)
    ) u_dut (
      .clk          (clk),
      .rst          (rst),
      .clr          (clr),
      .wen          (wen),
      .din          (din),
      .full         (full_w[g]),
      .almost_full  (afull_w[g]),
      .ren          (ren),
      .dout         (dout_w[g]),
      .empty        (empty_w[g]),
      .almost_empty (aempty_w[g]),
      .count        (count_w[g]),
      .overflow     (ovf_w[g]),
      .underflow    (udf_w[g])
    );
  end

  // Model: circular queue of held words; each word records the clock edge after which
  // it may be presented (one edge later in fall-through mode).
  logic [7:0] md [2][8];
  int         mr [2][8];
  int         mh [2];
  int         ms [2];
  logic [7:0] mlast [2];
  bit         movf [2];
  bit         mudf [2];
  int         cyc = 0;

  function automatic bit m_vis(input int k);
    return ms[k] > 0 && cyc >= mr[k][mh[k]];
  endfunction

  // Full when the words not yet presented fill the RAM.
  function automatic bit m_full(input int k);
    return (ms[k] - ((k == 1 && m_vis(k)) ? 1 : 0)) == Depth;
  endfunction

  task automatic model_update();
    for (int k = 0; k < 2; k++) begin
      bit vis, fl;
      int idx;
      if (rst || clr) begin
        ms[k] = 0; mh[k] = 0; movf[k] = 1'b0; mudf[k] = 1'b0; mlast[k] = 8'h00;
      end else begin
        vis = m_vis(k);
        fl  = m_full(k);
        if (ren && !vis) mudf[k] = 1'b1;
        if (wen && fl) movf[k] = 1'b1;
        if (ren && vis) begin
          mlast[k] = md[k][mh[k]];
          mh[k] = (mh[k] + 1) % 8;
          ms[k] = ms[k] - 1;
        end
        if (wen && !fl) begin
          idx = (mh[k] + ms[k]) % 8;
          md[k][idx] = din;
          mr[k][idx] = cyc + 1 + k;
          ms[k] = ms[k] + 1;
        end
      end
    end
    cyc++;
  endtask

  task automatic chk(input string nm, input int k, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s fwft=%0d got=%0h want=%0h t=%0t", nm, k, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      for (int k = 0; k < 2; k++) begin
        chk("empty", k, empty_w[k], !m_vis(k));
        chk("full", k, full_w[k], m_full(k));
        chk("count", k, count_w[k], ms[k]);
        chk("almost_full", k, afull_w[k], ms[k] >= 2);
        chk("almost_empty", k, aempty_w[k], ms[k] <= 1);
        chk("overflow", k, ovf_w[k], movf[k]);
        chk("underflow", k, udf_w[k], mudf[k]);
        if (k == 0) chk("dout", k, dout_w[k], mlast[k]);
        else if (m_vis(k)) chk("dout", k, dout_w[k], md[k][mh[k]]);
      end
    end
  end

  task automatic step(input bit w, input bit r, input logic [7:0] d, input bit c, input bit rs);
    @(negedge clk);
    wen = w; ren = r; din = d; clr = c; rst = rs;
    @(posedge clk);
    #1;
    model_update();
  endtask

  task automatic chk_reset_state(input string nm);
    for (int k = 0; k < 2; k++) begin
      chk({nm, "_empty"}, k, empty_w[k], 1);
      chk({nm, "_full"}, k, full_w[k], 0);
      chk({nm, "_count"}, k, count_w[k], 0);
      chk({nm, "_dout"}, k, dout_w[k], 0);
      chk({nm, "_ovf"}, k, ovf_w[k], 0);
      chk({nm, "_udf"}, k, udf_w[k], 0);
      chk({nm, "_aempty"}, k, aempty_w[k], 1);
      chk({nm, "_afull"}, k, afull_w[k], 0);
    end
  endtask

  initial begin
    rst = 1'b1; clr = 1'b0; wen = 1'b0; ren = 1'b0; din = 8'h00;
    step(0, 0, 8'h00, 0, 1);
    step(0, 0, 8'h00, 0, 1);
    chk_en = 1'b1;
    chk_reset_state("reset");

    // Single word through the fall-through stage.
    step(1, 0, 8'hA1, 0, 0);
    chk("single_cnt_c1", 1, count_w[1], 1);
    chk("single_empty_c1", 1, empty_w[1], 1);
    step(0, 0, 8'h00, 0, 0);
    chk("single_empty_c2", 1, empty_w[1], 0);
    chk("single_dout_c2", 1, dout_w[1], 8'hA1);
    step(0, 1, 8'h00, 0, 0);
    chk("single_pop_empty", 1, empty_w[1], 1);
    chk("single_pop_cnt", 1, count_w[1], 0);
    chk("std_pop_dout", 0, dout_w[0], 8'hA1);

    // Fill past capacity, then drain in order.
    for (int i = 1; i <= 6; i++) step(1, 0, 8'(i), 0, 0);
    chk("fill_cnt", 1, count_w[1], 5);
    chk("fill_full", 1, full_w[1], 1);
    chk("fill_afull", 1, afull_w[1], 1);
    chk("fill_ovf", 1, ovf_w[1], 1);
    chk("fill_cnt", 0, count_w[0], 4);
    chk("model_fill_cnt", 1, ms[1], 5);
    for (int i = 1; i <= 5; i++) begin
      chk("drain_dout", 1, dout_w[1], i);
      step(0, 1, 8'h00, 0, 0);
    end
    chk("drain_udf", 1, udf_w[1], 0);
    chk("drain_empty", 1, empty_w[1], 1);

    // Streaming one word per cycle.
    step(0, 0, 8'h00, 1, 0);
    step(1, 0, 8'd0, 0, 0);
    step(1, 0, 8'd1, 0, 0);
    for (int i = 0; i < 100; i++) begin
      step(1, 1, 8'(i + 2), 0, 0);
      chk("stream_cnt", 1, count_w[1], 2);
    end
    for (int k = 0; k < 2; k++) begin
      chk("stream_ovf", k, ovf_w[k], 0);
      chk("stream_udf", k, udf_w[k], 0);
    end

    // Underflow, then flush with words held.
    step(0, 0, 8'h00, 1, 0);
    step(0, 1, 8'h00, 0, 0);
    chk("udf_set", 1, udf_w[1], 1);
    chk("udf_cnt", 1, count_w[1], 0);
    for (int i = 0; i < 3; i++) step(1, 0, 8'(8'h30 + i), 0, 0);
    step(0, 0, 8'h00, 1, 0);
    for (int k = 0; k < 2; k++) begin
      chk("clr_empty", k, empty_w[k], 1);
      chk("clr_cnt", k, count_w[k], 0);
      chk("clr_ovf", k, ovf_w[k], 0);
      chk("clr_udf", k, udf_w[k], 0);
    end

    // Standard mode read latency.
    step(1, 0, 8'h55, 0, 0);
    step(0, 1, 8'h00, 0, 0);
    chk("std_dout", 0, dout_w[0], 8'h55);
    chk("std_empty", 0, empty_w[0], 1);

    // Random traffic with occasional flush.
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 99) < 55, $urandom_range(0, 99) < 50, 8'($urandom),
           $urandom_range(0, 59) == 0, 0);
    end

    // Reset with words queued.
    step(0, 0, 8'h00, 1, 0);
    for (int i = 0; i < 3; i++) step(1, 0, 8'(8'hC0 + i), 0, 0);
    step(1, 1, 8'hEE, 0, 1);
    chk_reset_state("midrst");
    step(0, 0, 8'h00, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
